// File: rtl/sdram_pkg.sv
// sdram_pkg
//   Shared types and defaults for the SDRAM request arbiter slice.
//   - sdram_addr_t : 25-bit byte address
//   - port_e       : client identifier, also the fixed-priority order (dl > vid > cpu)
//   - arb_state_e  : arbiter FSM states
//   - burst_align  : clears addr[1:0] so a 2x16-bit read burst stays 32-bit aligned
package sdram_pkg;

   localparam int unsigned ADDR_W        = 25;
   localparam int unsigned INIT_WAIT_DEF = 15100;
   localparam int unsigned CAP0_DEF      = 7;
   localparam int unsigned CAP1_DEF      = 8;
   localparam int unsigned LAST_DEF      = 15;

   typedef logic [ADDR_W-1:0] sdram_addr_t;

   typedef enum logic [1:0] {
      PORT_DL  = 2'd0,
      PORT_VID = 2'd1,
      PORT_CPU = 2'd2
   } port_e;

   typedef enum logic [1:0] {
      ST_WAIT_INIT = 2'd0,
      ST_IDLE      = 2'd1,
      ST_RUN       = 2'd2
   } arb_state_e;

   function automatic sdram_addr_t burst_align(input sdram_addr_t a);
      return {a[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/sdram_rd_capture.sv
// sdram_rd_capture
//   Read-burst capture for one client: samples the SDRAM data pins into the low
//   half at CAP0 and the high half at CAP1, then pulses o_valid for one clock.
// Ports
//   clk       in   1   controller clock
//   reset_n   in   1   asynchronous active-low reset
//   i_active  in   1   this client owns the current read cycle
//   i_cycle   in   5   controller sm_cycle
//   i_dq      in   16  SDRAM data pins
//   o_dout    out  32  {word1, word0}
//   o_valid   out  1   one-clock pulse on the clock after CAP1
module sdram_rd_capture
   import sdram_pkg::*;
#(
   parameter int unsigned CAP0 = CAP0_DEF,
   parameter int unsigned CAP1 = CAP1_DEF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_active,
   input  logic [4:0]  i_cycle,
   input  logic [15:0] i_dq,
   output logic [31:0] o_dout,
   output logic        o_valid
);

   localparam logic [4:0] CAP0_C = 5'(CAP0);
   localparam logic [4:0] CAP1_C = 5'(CAP1);

   logic [15:0] r_w0;
   logic [15:0] r_w1;
   logic        r_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_w0    <= '0;
         r_w1    <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (i_active && (i_cycle == CAP0_C)) begin
            r_w0 <= i_dq;
         end
         if (i_active && (i_cycle == CAP1_C)) begin
            r_w1    <= i_dq;
            r_valid <= 1'b1;
         end
      end
   end

   assign o_dout  = {r_w1, r_w0};
   assign o_valid = r_valid;

endmodule

// File: rtl/sdram_port_arb.sv
// sdram_port_arb
//   Merges three clients (ROM-download byte writer, video reader, CPU reader) onto
//   the SDRAM controller's single we/rd/addr/di port. A granted request is held
//   stable for a full 16-state controller cycle; read bursts are captured per port.
// Ports
//   clk, reset_n                 controller clock, asynchronous active-low reset
//   dl_wr/dl_addr/dl_data        byte write request; dl_ack pulses on completion
//   vid_rd/vid_addr              32-bit read request; vid_dout/vid_valid result
//   cpu_rd/cpu_addr              32-bit read request; cpu_dout/cpu_valid result
//   sd_dq_in                     SDRAM data pins
//   ctl_cycle                    controller sm_cycle
//   ctl_we/ctl_rd/ctl_addr/ctl_di  request to the controller
module sdram_port_arb
   import sdram_pkg::*;
#(
   parameter int unsigned INIT_WAIT = INIT_WAIT_DEF,
   parameter int unsigned CAP0      = CAP0_DEF,
   parameter int unsigned CAP1      = CAP1_DEF,
   parameter int unsigned LAST      = LAST_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              dl_wr,
   input  logic [ADDR_W-1:0] dl_addr,
   input  logic [7:0]        dl_data,
   output logic              dl_ack,
   input  logic              vid_rd,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic [31:0]       vid_dout,
   output logic              vid_valid,
   input  logic              cpu_rd,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic [31:0]       cpu_dout,
   output logic              cpu_valid,
   input  logic [15:0]       sd_dq_in,
   input  logic [4:0]        ctl_cycle,
   output logic              ctl_we,
   output logic              ctl_rd,
   output logic [ADDR_W-1:0] ctl_addr,
   output logic [7:0]        ctl_di
);

   localparam int unsigned CNT_W  = (INIT_WAIT < 2) ? 1 : $clog2(INIT_WAIT + 1);
   localparam logic [4:0]  LAST_C = 5'(LAST);

   arb_state_e  r_state;
   arb_state_e  w_state_nxt;
   logic [CNT_W-1:0] r_init_cnt;

   logic        r_dl_pend;
   sdram_addr_t r_dl_addr;
   logic [7:0]  r_dl_data;
   logic        r_vid_pend;
   sdram_addr_t r_vid_addr;
   logic        r_cpu_pend;
   sdram_addr_t r_cpu_addr;

   port_e       r_port;
   logic        r_ctl_we;
   logic        r_ctl_rd;
   sdram_addr_t r_ctl_addr;
   logic [7:0]  r_ctl_di;
   logic        r_dl_ack;

   logic        w_any;
   logic        w_cyc_zero;
   logic        w_at_last;
   logic        w_grant;
   logic        w_finish;
   port_e       w_sel;
   logic        w_dl_gnt;
   logic        w_vid_gnt;
   logic        w_cpu_gnt;
   logic        w_vid_active;
   logic        w_cpu_active;

   assign w_any      = r_dl_pend | r_vid_pend | r_cpu_pend;
   assign w_cyc_zero = (ctl_cycle == 5'd0);
   assign w_at_last  = (ctl_cycle == LAST_C);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_WAIT_INIT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- FSM: next state ----------------
   // The controller has no reset, so after init we still wait for its cycle
   // counter to come round to 0 rather than starting mid-cycle.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_WAIT_INIT: if (r_init_cnt == '0)          w_state_nxt = ST_IDLE;
         ST_IDLE:      if (w_any && w_cyc_zero)       w_state_nxt = ST_RUN;
         ST_RUN:       if (w_at_last)                 w_state_nxt = ST_IDLE;
         default:                                     w_state_nxt = ST_WAIT_INIT;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      w_grant  = (r_state == ST_IDLE) && w_any && w_cyc_zero;
      w_finish = (r_state == ST_RUN) && w_at_last;
      if (r_dl_pend) begin
         w_sel = PORT_DL;
      end else if (r_vid_pend) begin
         w_sel = PORT_VID;
      end else begin
         w_sel = PORT_CPU;
      end
   end

   assign w_dl_gnt  = w_grant && (w_sel == PORT_DL);
   assign w_vid_gnt = w_grant && (w_sel == PORT_VID);
   assign w_cpu_gnt = w_grant && (w_sel == PORT_CPU);

   // ---------------- init wait counter ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_init_cnt <= CNT_W'(INIT_WAIT);
      end else if ((r_state == ST_WAIT_INIT) && (r_init_cnt != '0)) begin
         r_init_cnt <= r_init_cnt - CNT_W'(1);
      end
   end

   // ---------------- pending flags ----------------
   // A pulse wins over the grant-clear, so a request arriving on the very
   // clock its predecessor is granted stays pending with its own address.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dl_pend  <= 1'b0;
         r_dl_addr  <= '0;
         r_dl_data  <= '0;
         r_vid_pend <= 1'b0;
         r_vid_addr <= '0;
         r_cpu_pend <= 1'b0;
         r_cpu_addr <= '0;
      end else begin
         if (dl_wr) begin
            r_dl_pend <= 1'b1;
            r_dl_addr <= dl_addr;
            r_dl_data <= dl_data;
         end else if (w_dl_gnt) begin
            r_dl_pend <= 1'b0;
         end

         if (vid_rd) begin
            r_vid_pend <= 1'b1;
            r_vid_addr <= vid_addr;
         end else if (w_vid_gnt) begin
            r_vid_pend <= 1'b0;
         end

         if (cpu_rd) begin
            r_cpu_pend <= 1'b1;
            r_cpu_addr <= cpu_addr;
         end else if (w_cpu_gnt) begin
            r_cpu_pend <= 1'b0;
         end
      end
   end

   // ---------------- controller request registers ----------------
   // we/rd drop on the LAST edge so the controller sees them low at state 0;
   // the address is left as-is since it is only qualified by we/rd.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_port     <= PORT_DL;
         r_ctl_we   <= 1'b0;
         r_ctl_rd   <= 1'b0;
         r_ctl_addr <= '0;
         r_ctl_di   <= '0;
         r_dl_ack   <= 1'b0;
      end else begin
         r_dl_ack <= w_finish && (r_port == PORT_DL);
         if (w_grant) begin
            r_port <= w_sel;
            unique case (w_sel)
               PORT_DL: begin
                  r_ctl_we   <= 1'b1;
                  r_ctl_rd   <= 1'b0;
                  r_ctl_addr <= r_dl_addr;
                  r_ctl_di   <= r_dl_data;
               end
               PORT_VID: begin
                  r_ctl_we   <= 1'b0;
                  r_ctl_rd   <= 1'b1;
                  r_ctl_addr <= burst_align(r_vid_addr);
                  r_ctl_di   <= '0;
               end
               default: begin
                  r_ctl_we   <= 1'b0;
                  r_ctl_rd   <= 1'b1;
                  r_ctl_addr <= burst_align(r_cpu_addr);
                  r_ctl_di   <= '0;
               end
            endcase
         end else if (w_finish) begin
            r_ctl_we <= 1'b0;
            r_ctl_rd <= 1'b0;
         end
      end
   end

   assign ctl_we   = r_ctl_we;
   assign ctl_rd   = r_ctl_rd;
   assign ctl_addr = r_ctl_addr;
   assign ctl_di   = r_ctl_di;
   assign dl_ack   = r_dl_ack;

   // ---------------- read capture ----------------
   assign w_vid_active = (r_state == ST_RUN) && (r_port == PORT_VID);
   assign w_cpu_active = (r_state == ST_RUN) && (r_port == PORT_CPU);

   sdram_rd_capture #(
      .CAP0 (CAP0),
      .CAP1 (CAP1)
   ) u_vid_cap (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_active (w_vid_active),
      .i_cycle  (ctl_cycle),
      .i_dq     (sd_dq_in),
      .o_dout   (vid_dout),
      .o_valid  (vid_valid)
   );

   sdram_rd_capture #(
      .CAP0 (CAP0),
      .CAP1 (CAP1)
   ) u_cpu_cap (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_active (w_cpu_active),
      .i_cycle  (ctl_cycle),
      .i_dq     (sd_dq_in),
      .o_dout   (cpu_dout),
      .o_valid  (cpu_valid)
   );

endmodule

// File: tb/tb_sdram_port_arb.sv
// tb_sdram_port_arb
//   Directed bench for sdram_port_arb. A free-running 16-state controller cycle
//   (never reset) and a simple memory model (word w reads back {w[7:0], ~w[7:0]})
//   drive the DUT; expected values below are hand-computed from that model.
module tb_sdram_port_arb;

   logic        clk      = 1'b0;
   logic        reset_n  = 1'b0;
   logic        dl_wr    = 1'b0;
   logic [24:0] dl_addr  = '0;
   logic [7:0]  dl_data  = '0;
   logic        dl_ack;
   logic        vid_rd   = 1'b0;
   logic [24:0] vid_addr = '0;
   logic [31:0] vid_dout;
   logic        vid_valid;
   logic        cpu_rd   = 1'b0;
   logic [24:0] cpu_addr = '0;
   logic [31:0] cpu_dout;
   logic        cpu_valid;
   logic [15:0] sd_dq_in;
   logic [4:0]  ctl_cycle = 5'd3;
   logic        ctl_we;
   logic        ctl_rd;
   logic [24:0] ctl_addr;
   logic [7:0]  ctl_di;

   int          n_vec = 0;
   int          n_err = 0;
   int          vid_cnt = 0;
   int          cpu_cnt = 0;
   logic [31:0] vid_last = '0;
   logic [31:0] cpu_last = '0;
   logic [4:0]  vid_vcyc = '0;

   sdram_port_arb #(
      .INIT_WAIT (15100),
      .CAP0      (7),
      .CAP1      (8),
      .LAST      (15)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .dl_wr     (dl_wr),
      .dl_addr   (dl_addr),
      .dl_data   (dl_data),
      .dl_ack    (dl_ack),
      .vid_rd    (vid_rd),
      .vid_addr  (vid_addr),
      .vid_dout  (vid_dout),
      .vid_valid (vid_valid),
      .cpu_rd    (cpu_rd),
      .cpu_addr  (cpu_addr),
      .cpu_dout  (cpu_dout),
      .cpu_valid (cpu_valid),
      .sd_dq_in  (sd_dq_in),
      .ctl_cycle (ctl_cycle),
      .ctl_we    (ctl_we),
      .ctl_rd    (ctl_rd),
      .ctl_addr  (ctl_addr),
      .ctl_di    (ctl_di)
   );

   always #5 clk = ~clk;

   // controller state counter: free running, unaffected by reset_n
   always @(posedge clk) ctl_cycle <= (ctl_cycle == 5'd15) ? 5'd0 : ctl_cycle + 5'd1;

   function automatic logic [15:0] mem_word(input logic [23:0] w);
      return {w[7:0], ~w[7:0]};
   endfunction

   // burst words appear on the pins at states 7 and 8 for the current address
   always_comb begin
      sd_dq_in = 16'hDEAD;
      if (ctl_cycle == 5'd7)      sd_dq_in = mem_word(ctl_addr[24:1]);
      else if (ctl_cycle == 5'd8) sd_dq_in = mem_word(ctl_addr[24:1] + 24'd1);
   end

   always @(posedge clk) begin
      if (vid_valid) begin
         vid_cnt  = vid_cnt + 1;
         vid_last = vid_dout;
         vid_vcyc = ctl_cycle;
      end
      if (cpu_valid) begin
         cpu_cnt  = cpu_cnt + 1;
         cpu_last = cpu_dout;
      end
   end

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic pulse_dl(input logic [24:0] a, input logic [7:0] d);
      dl_addr = a; dl_data = d; dl_wr = 1'b1;
      @(negedge clk);
      dl_wr = 1'b0;
   endtask

   task automatic pulse_vid(input logic [24:0] a);
      vid_addr = a; vid_rd = 1'b1;
      @(negedge clk);
      vid_rd = 1'b0;
   endtask

   task automatic pulse_cpu(input logic [24:0] a);
      cpu_addr = a; cpu_rd = 1'b1;
      @(negedge clk);
      cpu_rd = 1'b0;
   endtask

   task automatic wait_req(input int max, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(ctl_we || ctl_rd) && n < max);
   endtask

   task automatic wait_low(input int max);
      int n;
      n = 0;
      while ((ctl_we || ctl_rd) && n < max) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_cycle(input logic [4:0] c, input int max);
      int n;
      n = 0;
      while (ctl_cycle != c && n < max) begin
         @(negedge clk);
         n++;
      end
   endtask

   // from an active request, clocks to the next rising request and low samples between
   task automatic next_grant(input int max, output int spacing, output int gap);
      logic seen_low;
      seen_low = 1'b0;
      spacing  = 0;
      gap      = 0;
      while (spacing < max) begin
         @(negedge clk);
         spacing++;
         if (!(ctl_we || ctl_rd)) begin
            gap++;
            seen_low = 1'b1;
         end else if (seen_low) begin
            break;
         end
      end
   endtask

   task automatic wait_vid(input int target, input int max);
      int n;
      n = 0;
      while (vid_cnt < target && n < max) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_cpu(input int target, input int max);
      int n;
      n = 0;
      while (cpu_cnt < target && n < max) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int n, sp, gap, hi, acks, chg, base, rises;
      logic prev;

      // ---- reset state ----
      repeat (3) @(negedge clk);
      check_vec("rst_flags", 32'({ctl_we, ctl_rd, dl_ack, vid_valid, cpu_valid}), 32'd0);
      check_vec("rst_addr", 32'(ctl_addr), 32'd0);
      check_vec("rst_vid_dout", vid_dout, 32'd0);

      // ---- 1: read requested during init wait ----
      reset_n = 1'b1;
      pulse_vid(25'h000100);
      wait_req(15200, n);
      check_vec("t1_init_wait", 32'(((n + 1) >= 15102) && ((n + 1) <= 15117)), 32'd1);
      check_vec("t1_rd", 32'({ctl_we, ctl_rd}), 32'b01);
      check_vec("t1_grant_cyc", 32'(ctl_cycle), 32'd1);
      check_vec("t1_addr", 32'(ctl_addr), 32'h100);
      wait_vid(1, 40);
      check_vec("t1_vid_cnt", 32'(vid_cnt), 32'd1);
      check_vec("t1_vid_dout", vid_last, 32'h817E_807F);
      check_vec("t1_valid_cyc", 32'(vid_vcyc), 32'd9);
      wait_low(40);
      check_vec("t1_rd_drop_cyc", 32'(ctl_cycle), 32'd0);

      // ---- 2: single byte write ----
      pulse_dl(25'h000003, 8'hA5);
      wait_req(40, n);
      check_vec("t2_we", 32'({ctl_we, ctl_rd}), 32'b10);
      check_vec("t2_addr", 32'(ctl_addr), 32'h3);
      check_vec("t2_di", 32'(ctl_di), 32'hA5);
      check_vec("t2_grant_cyc", 32'(ctl_cycle), 32'd1);
      hi = 1; chg = 0; acks = 0;
      for (int i = 0; i < 40 && ctl_we; i++) begin
         @(negedge clk);
         if (ctl_we) begin
            hi++;
            if (ctl_addr != 25'h3 || ctl_di != 8'hA5) chg++;
         end
      end
      check_vec("t2_we_len", 32'(hi), 32'd15);
      check_vec("t2_hold", 32'(chg), 32'd0);
      check_vec("t2_drop_cyc", 32'(ctl_cycle), 32'd0);
      check_vec("t2_ack", 32'(dl_ack), 32'd1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (dl_ack) acks++;
      end
      check_vec("t2_ack_once", 32'(acks), 32'd0);

      // ---- 3: all three clients in the same clock ----
      base = cpu_cnt;
      n    = vid_cnt;
      dl_addr = 25'h000011; dl_data = 8'h3C; dl_wr = 1'b1;
      vid_addr = 25'h000040; vid_rd = 1'b1;
      cpu_addr = 25'h000082; cpu_rd = 1'b1;
      @(negedge clk);
      dl_wr = 1'b0; vid_rd = 1'b0; cpu_rd = 1'b0;
      wait_req(40, sp);
      check_vec("t3_g1_we", 32'({ctl_we, ctl_rd}), 32'b10);
      check_vec("t3_g1_addr", 32'(ctl_addr), 32'h11);
      check_vec("t3_g1_di", 32'(ctl_di), 32'h3C);
      next_grant(40, sp, gap);
      check_vec("t3_g2_spacing", 32'(sp), 32'd16);
      check_vec("t3_g2_gap", 32'(gap), 32'd1);
      check_vec("t3_g2_rd", 32'({ctl_we, ctl_rd}), 32'b01);
      check_vec("t3_g2_addr", 32'(ctl_addr), 32'h40);
      next_grant(40, sp, gap);
      check_vec("t3_g3_spacing", 32'(sp), 32'd16);
      check_vec("t3_g3_gap", 32'(gap), 32'd1);
      check_vec("t3_g3_addr", 32'(ctl_addr), 32'h80);
      wait_cpu(base + 1, 40);
      check_vec("t3_vid_cnt", 32'(vid_cnt - n), 32'd1);
      check_vec("t3_vid_dout", vid_last, 32'h21DE_20DF);
      check_vec("t3_cpu_cnt", 32'(cpu_cnt - base), 32'd1);
      check_vec("t3_cpu_dout", cpu_last, 32'h41BE_40BF);

      // ---- pulse in the same clock as that port's grant ----
      wait_low(40);
      wait_cycle(5'd14, 20);
      base = vid_cnt;
      pulse_vid(25'h000030);
      @(negedge clk);
      pulse_vid(25'h000050);
      check_vec("tp_g1_addr", 32'(ctl_addr), 32'h30);
      check_vec("tp_g1_cyc", 32'(ctl_cycle), 32'd1);
      next_grant(40, sp, gap);
      check_vec("tp_g2_spacing", 32'(sp), 32'd16);
      check_vec("tp_g2_addr", 32'(ctl_addr), 32'h50);
      wait_vid(base + 2, 60);
      check_vec("tp_vid_cnt", 32'(vid_cnt - base), 32'd2);
      check_vec("tp_vid_dout", vid_last, 32'h29D6_28D7);

      // ---- 4: unaligned CPU read ----
      wait_low(40);
      base = cpu_cnt;
      pulse_cpu(25'h000006);
      wait_req(40, n);
      check_vec("t4_rd", 32'({ctl_we, ctl_rd}), 32'b01);
      check_vec("t4_addr", 32'(ctl_addr), 32'h4);
      wait_cpu(base + 1, 40);
      check_vec("t4_cpu_cnt", 32'(cpu_cnt - base), 32'd1);
      check_vec("t4_cpu_dout", cpu_last, 32'h03FC_02FD);

      // ---- 6: two video pulses before the grant, last one wins ----
      wait_low(40);
      wait_cycle(5'd2, 20);
      base = vid_cnt;
      pulse_vid(25'h000010);
      pulse_vid(25'h000020);
      wait_req(40, n);
      check_vec("t6_addr", 32'(ctl_addr), 32'h20);
      rises = 0;
      prev  = ctl_rd;
      for (int i = 0; i < 48; i++) begin
         @(negedge clk);
         if (ctl_rd && !prev) rises++;
         prev = ctl_rd;
      end
      check_vec("t6_single_read", 32'(rises), 32'd0);
      check_vec("t6_vid_cnt", 32'(vid_cnt - base), 32'd1);
      check_vec("t6_vid_dout", vid_last, 32'h11EE_10EF);

      // ---- 5: reset asserted mid-cycle ----
      pulse_cpu(25'h000100);
      wait_req(40, n);
      check_vec("t5_pre_rd", 32'(ctl_rd), 32'd1);
      wait_cycle(5'd5, 20);
      reset_n = 1'b0;
      #1;
      check_vec("t5_async_flags", 32'({ctl_we, ctl_rd, dl_ack, vid_valid, cpu_valid}), 32'd0);
      check_vec("t5_async_addr", 32'(ctl_addr), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      base = cpu_cnt;
      pulse_cpu(25'h000008);
      wait_req(15200, n);
      check_vec("t5_init_wait", 32'(((n + 1) >= 15102) && ((n + 1) <= 15117)), 32'd1);
      check_vec("t5_grant_cyc", 32'(ctl_cycle), 32'd1);
      check_vec("t5_addr", 32'(ctl_addr), 32'h8);
      wait_cpu(base + 1, 40);
      check_vec("t5_cpu_cnt", 32'(cpu_cnt - base), 32'd1);
      check_vec("t5_cpu_dout", cpu_last, 32'h05FA_04FB);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
